// File: rtl/pm_msg_pkg.sv
// rtl/pm_msg_pkg.sv - PM sideband message codes and PM handshake FSM states
// Shared by the PM entry responder and initiator.
package pm_msg_pkg;

    localparam logic [3:0] MSG_REQ_L1    = 4'd2;
    localparam logic [3:0] MSG_REQ_L2    = 4'd3;
    localparam logic [3:0] MSG_RSP_PMNAK = 4'd9;
    localparam logic [3:0] MSG_RSP_L1    = 4'd10;
    localparam logic [3:0] MSG_RSP_L2    = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_SEND_RSP,
        ST_WAIT_DONE,
        ST_DONE
    } pm_state_t;

    function automatic logic is_pm_req(input logic [3:0] code);
        return (code == MSG_REQ_L1) || (code == MSG_REQ_L2);
    endfunction

    // Agreed state is the shallower of the two requests; no local request means NAK.
    function automatic logic [3:0] pick_rsp(input logic local_req, input logic local_l2,
                                            input logic [3:0] remote_code);
        if (!local_req)
            return MSG_RSP_PMNAK;
        if (local_l2 && (remote_code == MSG_REQ_L2))
            return MSG_RSP_L2;
        return MSG_RSP_L1;
    endfunction

endpackage

// File: rtl/pm_timeout_counter.sv
// rtl/pm_timeout_counter.sv - saturating wait counter, expires at TIMEOUT_CYCLES-1
module pm_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 800,
    parameter int CNT_W          = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pm_entry_responder.sv
// rtl/pm_entry_responder.sv - answers a remote PM entry request over sideband
// Optional WAIT_REQ timeout is built only when PM_RSP_TIMEOUT_EN is defined.
module pm_entry_responder
    import pm_msg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800,
    parameter int CNT_W          = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_local_pm_req,
    input  logic       i_local_req_L1_or_L2,
    input  logic       i_msg_valid,
    input  logic [3:0] i_msg_no,
    input  logic       i_msg_done,
    output logic       o_msg_valid,
    output logic [3:0] o_msg_no,
    output logic       o_test_done,
    output logic       o_pm_nak,
    output logic       o_entered_L1,
    output logic       o_entered_L2,
    output logic       o_timeout
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**CNT_W) begin : g_bad_cfg
        $error("pm_entry_responder: TIMEOUT_CYCLES must fit in CNT_W bits");
    end

    pm_state_t  r_state;
    pm_state_t  w_next;
    logic [3:0] r_rsp_no;
    logic       w_req_hit;
    logic       w_expired;

    assign w_req_hit = i_msg_valid && is_pm_req(i_msg_no);

`ifdef PM_RSP_TIMEOUT_EN
    logic r_timeout;

    pm_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (r_state != ST_WAIT_REQ),
        .i_enable (r_state == ST_WAIT_REQ),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_timeout <= 1'b0;
        else if (r_state == ST_IDLE)
            r_timeout <= 1'b0;
        else if (r_state == ST_WAIT_REQ && i_en && !w_req_hit && w_expired)
            r_timeout <= 1'b1;
    end

    assign o_timeout = (r_state == ST_DONE) && r_timeout;
`else
    assign w_expired = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (i_en) w_next = ST_WAIT_REQ;
            ST_WAIT_REQ:  if (w_req_hit) w_next = ST_SEND_RSP;
                          else if (w_expired) w_next = ST_DONE;
            ST_SEND_RSP:  w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (i_msg_done) w_next = ST_DONE;
            ST_DONE:      w_next = ST_DONE;
            default:      w_next = ST_IDLE;
        endcase
        if (!i_en)
            w_next = ST_IDLE;
    end

    // Response code is cleared in IDLE so a timed-out DONE reports no agreed state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_rsp_no <= '0;
        else if (r_state == ST_IDLE)
            r_rsp_no <= '0;
        else if (r_state == ST_WAIT_REQ && i_en && w_req_hit)
            r_rsp_no <= pick_rsp(i_local_pm_req, i_local_req_L1_or_L2, i_msg_no);
    end

    always_comb begin
        o_msg_valid  = (r_state == ST_SEND_RSP) || (r_state == ST_WAIT_DONE);
        o_msg_no     = o_msg_valid ? r_rsp_no : 4'd0;
        o_test_done  = (r_state == ST_DONE);
        o_pm_nak     = (r_state == ST_DONE) && (r_rsp_no == MSG_RSP_PMNAK);
        o_entered_L1 = (r_state == ST_DONE) && (r_rsp_no == MSG_RSP_L1);
        o_entered_L2 = (r_state == ST_DONE) && (r_rsp_no == MSG_RSP_L2);
    end

endmodule

// File: tb/tb_pm_entry_responder.sv
// tb/tb_pm_entry_responder.sv - self-checking bench for pm_entry_responder
// Timeout section depends on PM_RSP_TIMEOUT_EN.
module tb_pm_entry_responder;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic       i_local_pm_req;
    logic       i_local_req_L1_or_L2;
    logic       i_msg_valid;
    logic [3:0] i_msg_no;
    logic       i_msg_done;
    logic       o_msg_valid;
    logic [3:0] o_msg_no;
    logic       o_test_done;
    logic       o_pm_nak;
    logic       o_entered_L1;
    logic       o_entered_L2;
    logic       o_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    pm_entry_responder #(
        .TIMEOUT_CYCLES(50),
        .CNT_W         (16)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_en                (i_en),
        .i_local_pm_req      (i_local_pm_req),
        .i_local_req_L1_or_L2(i_local_req_L1_or_L2),
        .i_msg_valid         (i_msg_valid),
        .i_msg_no            (i_msg_no),
        .i_msg_done          (i_msg_done),
        .o_msg_valid         (o_msg_valid),
        .o_msg_no            (o_msg_no),
        .o_test_done         (o_test_done),
        .o_pm_nak            (o_pm_nak),
        .o_entered_L1        (o_entered_L1),
        .o_entered_L2        (o_entered_L2),
        .o_timeout           (o_timeout)
    );

    typedef struct {
        bit         lreq;
        bit         ll2;
        logic [3:0] code;
        int         dly;
        int         exp_no;
        bit         exp_nak;
        bit         exp_l1;
        bit         exp_l2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input bit ev, input int eno, input bit edone,
                           input bit enak, input bit el1, input bit el2, input bit eto);
        chk({tag, ".msg_valid"}, 32'(o_msg_valid), 32'(ev));
        if (ev)
            chk({tag, ".msg_no"}, 32'(o_msg_no), eno);
        chk({tag, ".test_done"}, 32'(o_test_done), 32'(edone));
        chk({tag, ".pm_nak"}, 32'(o_pm_nak), 32'(enak));
        chk({tag, ".entered_L1"}, 32'(o_entered_L1), 32'(el1));
        chk({tag, ".entered_L2"}, 32'(o_entered_L2), 32'(el2));
        chk({tag, ".timeout"}, 32'(o_timeout), 32'(eto));
    endtask

    // Levels: L1=1, L2=2; the agreed level is the smaller one, response code = 9 + level.
    function automatic int model_rsp(input bit lreq, input bit ll2, input int code);
        int rl, ll;
        if (!lreq) return 9;
        rl = code - 1;
        ll = ll2 ? 2 : 1;
        return 9 + ((rl < ll) ? rl : ll);
    endfunction

    function automatic logic [3:0] noise_code();
        logic [3:0] pool [8] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd15};
        return pool[$urandom_range(0, 7)];
    endfunction

    task automatic run_txn(input string tag, input bit lreq, input bit ll2, input logic [3:0] code,
                           input int dly, input int noise, input int exp_no,
                           input bit enak, input bit el1, input bit el2);
        i_en = 1'b1;
        step();
        chk_out({tag, ".wait_req"}, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < noise; n++) begin
            i_msg_valid = 1'b1;
            i_msg_no    = noise_code();
            i_msg_done  = 1'($urandom_range(0, 1));
            step();
            chk_out({tag, ".noise"}, 0, 0, 0, 0, 0, 0, 0);
        end
        i_local_pm_req       = lreq;
        i_local_req_L1_or_L2 = ll2;
        i_msg_valid          = 1'b1;
        i_msg_no             = code;
        i_msg_done           = 1'b0;
        step();
        chk_out({tag, ".send_rsp"}, 1, exp_no, 0, 0, 0, 0, 0);
        i_local_pm_req       = 1'($urandom_range(0, 1));
        i_local_req_L1_or_L2 = 1'($urandom_range(0, 1));
        i_msg_valid          = 1'($urandom_range(0, 1));
        i_msg_no             = 4'(2 + $urandom_range(0, 1));
        i_msg_done           = 1'($urandom_range(0, 1));
        step();
        for (int k = 0; k <= dly; k++) begin
            chk_out({tag, ".wait_done"}, 1, exp_no, 0, 0, 0, 0, 0);
            i_msg_valid = 1'($urandom_range(0, 1));
            i_msg_no    = 4'(2 + $urandom_range(0, 1));
            i_msg_done  = (k == dly);
            step();
        end
        i_msg_done = 1'b0;
        for (int h = 0; h < 3; h++) begin
            chk_out({tag, ".done"}, 0, 0, 1, enak, el1, el2, 0);
            i_msg_valid = 1'($urandom_range(0, 1));
            i_msg_done  = 1'($urandom_range(0, 1));
            step();
        end
        i_en        = 1'b0;
        i_msg_valid = 1'b0;
        i_msg_done  = 1'b0;
        step();
        chk_out({tag, ".idle"}, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t vecs [7];
        int   exp_no;

        vecs[0] = '{1, 0, 4'd2, 0, 10, 0, 1, 0};
        vecs[1] = '{1, 0, 4'd3, 1, 10, 0, 1, 0};
        vecs[2] = '{0, 0, 4'd2, 0,  9, 1, 0, 0};
        vecs[3] = '{0, 1, 4'd3, 2,  9, 1, 0, 0};
        vecs[4] = '{1, 1, 4'd3, 0, 11, 0, 0, 1};
        vecs[5] = '{1, 1, 4'd2, 3, 10, 0, 1, 0};
        vecs[6] = '{1, 0, 4'd2, 4, 10, 0, 1, 0};

        i_rst = 1'b1;
        i_en = 1'b0;
        i_local_pm_req = 1'b0;
        i_local_req_L1_or_L2 = 1'b0;
        i_msg_valid = 1'b0;
        i_msg_no = 4'd0;
        i_msg_done = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
        step();
        i_rst = 1'b0;
        step();
        chk_out("post_reset", 0, 0, 0, 0, 0, 0, 0);

        for (int v = 0; v < 7; v++)
            run_txn($sformatf("vec%0d", v), vecs[v].lreq, vecs[v].ll2, vecs[v].code, vecs[v].dly,
                    v % 3, vecs[v].exp_no, vecs[v].exp_nak, vecs[v].exp_l1, vecs[v].exp_l2);

        for (int r = 0; r < 40; r++) begin
            bit         lreq, ll2;
            logic [3:0] code;
            lreq   = 1'($urandom_range(0, 1));
            ll2    = 1'($urandom_range(0, 1));
            code   = 4'(2 + $urandom_range(0, 1));
            exp_no = model_rsp(lreq, ll2, int'(code));
            run_txn($sformatf("rnd%0d", r), lreq, ll2, code, $urandom_range(0, 4),
                    $urandom_range(0, 3), exp_no, exp_no == 9, exp_no == 10, exp_no == 11);
        end

        // Abort in WAIT_DONE, then a clean matched L2.
        i_en = 1'b1;
        step();
        i_local_pm_req = 1'b1;
        i_local_req_L1_or_L2 = 1'b1;
        i_msg_valid = 1'b1;
        i_msg_no = 4'd3;
        step();
        i_msg_valid = 1'b0;
        step();
        chk_out("abort.wait_done", 1, 11, 0, 0, 0, 0, 0);
        i_en = 1'b0;
        step();
        chk_out("abort.idle", 0, 0, 0, 0, 0, 0, 0);
        run_txn("abort.restart", 1, 1, 4'd3, 1, 0, 11, 0, 0, 1);

        // Noise code 5 ignored, then reset mid-WAIT_DONE.
        i_en = 1'b1;
        step();
        i_msg_valid = 1'b1;
        i_msg_no = 4'd5;
        step();
        chk_out("noise5.a", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_out("noise5.b", 0, 0, 0, 0, 0, 0, 0);
        i_local_pm_req = 1'b1;
        i_local_req_L1_or_L2 = 1'b0;
        i_msg_no = 4'd2;
        step();
        i_msg_valid = 1'b0;
        step();
        chk_out("rst.wait_done", 1, 10, 0, 0, 0, 0, 0);
        #2;
        i_rst = 1'b1;
        #1;
        chk_out("rst.async", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_out("rst.held", 0, 0, 0, 0, 0, 0, 0);
        i_en = 1'b0;
        i_rst = 1'b0;
        step();
        chk_out("rst.released", 0, 0, 0, 0, 0, 0, 0);
        run_txn("rst.restart", 0, 0, 4'd2, 0, 1, 9, 1, 0, 0);

`ifdef PM_RSP_TIMEOUT_EN
        i_en = 1'b1;
        step();
        for (int k = 1; k < 50; k++) begin
            step();
            chk("timeout.early_done", 32'(o_test_done), 32'd0);
            chk("timeout.no_valid", 32'(o_msg_valid), 32'd0);
        end
        step();
        chk_out("timeout.fire", 0, 0, 1, 0, 0, 0, 1);
        step();
        chk_out("timeout.hold", 0, 0, 1, 0, 0, 0, 1);
        i_en = 1'b0;
        step();
        chk_out("timeout.idle", 0, 0, 0, 0, 0, 0, 0);
`else
        i_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            chk("notimeout.done", 32'(o_test_done), 32'd0);
            chk("notimeout.flag", 32'(o_timeout), 32'd0);
        end
        i_en = 1'b0;
        step();
        chk_out("notimeout.idle", 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
